// File: rtl/naive_mips_periph_pkg.sv
// Shared register map constants for the naive_mips peripheral bus slaves.
// Byte offsets, CTRL bit positions and STATUS bit positions live here.
package naive_mips_periph_pkg;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_COMPARE = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_DIV_LSB         = 8;
    localparam int CTRL_DIV_MSB         = 23;

    localparam int STATUS_MATCH_BIT = 0;

    // Word-aligns a byte address so it can be compared against the offsets.
    function automatic logic [3:0] word_offset(input logic [3:0] addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-(div+1) tick generator for bus_timer; counter holds at 0 while
// disabled or cleared, so the first tick comes div+1 cycles after enabling.
module timer_prescaler (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || (cnt == div)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped compare/match timer with level interrupt.
// Optional prescaler in CTRL[23:8] enabled by defining BUS_TIMER_PRESCALER_EN.
module bus_timer
    import naive_mips_periph_pkg::*;
#(
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic [3:0]  bus_address,
    input  logic [31:0] bus_data_i,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_data_o,
    output logic        irq
);

    // Bus access: bus_read/bus_write are single-cycle strobes with no ready;
    // a write commits at the next clk_bus edge, read data is combinational.
    logic        ctrl_en;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic [15:0] ctrl_div;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic        tick;

    logic [3:0] offset;
    logic       wr_ctrl;
    logic       wr_count;
    logic       wr_compare;
    logic       wr_status;
    logic       count_hit;
    logic       match_set;

    assign offset     = word_offset(bus_address);
    assign wr_ctrl    = bus_write && (offset == OFF_CTRL);
    assign wr_count   = bus_write && (offset == OFF_COUNT);
    assign wr_compare = bus_write && (offset == OFF_COMPARE);
    assign wr_status  = bus_write && (offset == OFF_STATUS);

    assign count_hit = (count == compare);
    // A COUNT write discards the tick, including any match it would have raised.
    assign match_set = tick && !wr_count && count_hit;

`ifdef BUS_TIMER_PRESCALER_EN
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_div <= '0;
        end else if (wr_ctrl) begin
            ctrl_div <= bus_data_i[CTRL_DIV_MSB:CTRL_DIV_LSB];
        end
    end

    timer_prescaler u_prescaler (
        .clk_bus (clk_bus),
        .rst_n   (rst_n),
        .en      (ctrl_en),
        .clr     (wr_ctrl),
        .div     (ctrl_div),
        .tick    (tick)
    );
`else
    assign ctrl_div = '0;
    assign tick     = ctrl_en;

    logic unused_div;
    assign unused_div = ^bus_data_i[CTRL_DIV_MSB:CTRL_DIV_LSB];
`endif

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            count            <= '0;
            compare          <= CMP_RESET;
            match            <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en          <= bus_data_i[CTRL_EN_BIT];
                ctrl_auto_reload <= bus_data_i[CTRL_AUTO_RELOAD_BIT];
                ctrl_irq_en      <= bus_data_i[CTRL_IRQ_EN_BIT];
            end
            if (wr_compare) begin
                compare <= bus_data_i;
            end
            if (wr_count) begin
                count <= bus_data_i;
            end else if (tick) begin
                count <= (count_hit && ctrl_auto_reload) ? 32'd0 : count + 32'd1;
            end
            if (match_set) begin
                match <= 1'b1;
            end else if (wr_status && bus_data_i[STATUS_MATCH_BIT]) begin
                match <= 1'b0;
            end
        end
    end

    always_comb begin
        bus_data_o = '0;
        case (offset)
            OFF_CTRL: begin
                bus_data_o[CTRL_EN_BIT]                = ctrl_en;
                bus_data_o[CTRL_AUTO_RELOAD_BIT]       = ctrl_auto_reload;
                bus_data_o[CTRL_IRQ_EN_BIT]            = ctrl_irq_en;
                bus_data_o[CTRL_DIV_MSB:CTRL_DIV_LSB]  = ctrl_div;
            end
            OFF_COUNT:   bus_data_o = count;
            OFF_COMPARE: bus_data_o = compare;
            OFF_STATUS:  bus_data_o[STATUS_MATCH_BIT] = match;
            default:     bus_data_o = '0;
        endcase
    end

    assign irq = match && ctrl_irq_en;

    logic unused_bus;
    assign unused_bus = ^{bus_read, bus_data_i[31:24], bus_data_i[7:3]};

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer; covers both the default build
// and the BUS_TIMER_PRESCALER_EN build.
module tb_bus_timer;

    logic        clk_bus;
    logic        rst_n;
    logic [3:0]  bus_address;
    logic [31:0] bus_data_i;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_data_o;
    logic        irq;

    int n_checks;
    int n_fail;

    bus_timer #(.CMP_RESET(32'hFFFF_FFFF)) dut (
        .clk_bus     (clk_bus),
        .rst_n       (rst_n),
        .bus_address (bus_address),
        .bus_data_i  (bus_data_i),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .bus_data_o  (bus_data_o),
        .irq         (irq)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        bus_address = addr;
        bus_read    = 1'b1;
        #1;
        check(tag, bus_data_o, exp);
        bus_read = 1'b0;
    endtask

    task automatic irq_check(input logic exp, input string tag);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
        bus_address = addr;
        bus_data_i  = data;
        bus_write   = 1'b1;
        @(posedge clk_bus);
        #1;
        bus_write  = 1'b0;
        bus_data_i = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_bus);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus_address = '0;
        bus_data_i  = '0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;

        // Reset values
        step(3);
        rst_n = 1'b1;
        read_check(4'h0, 32'h0, "rst_ctrl");
        read_check(4'h4, 32'h0, "rst_count");
        read_check(4'h8, 32'hFFFF_FFFF, "rst_compare");
        read_check(4'hC, 32'h0, "rst_status");
        irq_check(1'b0, "rst_irq");
        step(3);
        read_check(4'h4, 32'h0, "no_tick_before_en");

        // Match with auto-reload and interrupt, then W1C
        do_write(4'h8, 32'd5);
        do_write(4'h0, 32'h7);
        step(5);
        read_check(4'h4, 32'd5, "count_at_5");
        read_check(4'hC, 32'h0, "status_before_match");
        irq_check(1'b0, "irq_before_match");
        step(1);
        read_check(4'h4, 32'd0, "reload_to_0");
        read_check(4'hC, 32'h1, "match_set");
        irq_check(1'b1, "irq_on_match");
        do_write(4'hC, 32'h1);
        irq_check(1'b0, "irq_after_w1c");
        read_check(4'hC, 32'h0, "status_after_w1c");
        read_check(4'h4, 32'd1, "count_after_w1c");
        do_write(4'h0, 32'h0);
        read_check(4'h4, 32'd2, "count_at_disable");
        step(2);
        read_check(4'h4, 32'd2, "count_frozen");

        // Wrap without auto-reload, match only at COUNT==COMPARE
        do_write(4'h8, 32'd3);
        do_write(4'h4, 32'hFFFF_FFFE);
        do_write(4'h0, 32'h1);
        read_check(4'h4, 32'hFFFF_FFFE, "wrap_start");
        step(1);
        read_check(4'h4, 32'hFFFF_FFFF, "wrap_ff");
        read_check(4'hC, 32'h0, "wrap_no_flag");
        step(1);
        read_check(4'h4, 32'h0, "wrap_0");
        step(1);
        read_check(4'h4, 32'h1, "wrap_1");
        step(2);
        read_check(4'h4, 32'h3, "count_3");
        read_check(4'hC, 32'h0, "status_at_3");
        step(1);
        read_check(4'h4, 32'h4, "no_reload_plus1");
        read_check(4'hC, 32'h1, "match_no_reload");
        irq_check(1'b0, "irq_masked");

        // COUNT write beats tick; W1C coinciding with a new match
        do_write(4'h4, 32'h100);
        read_check(4'h4, 32'h100, "count_write_wins");
        do_write(4'h8, 32'h105);
        read_check(4'h4, 32'h101, "compare_write_keeps_count");
        step(4);
        read_check(4'h4, 32'h105, "count_at_105");
        do_write(4'hC, 32'h1);
        read_check(4'hC, 32'h1, "set_beats_w1c");
        read_check(4'h4, 32'h106, "count_after_match_105");
        do_write(4'hC, 32'h1);
        read_check(4'hC, 32'h0, "w1c_alone");

        // Read and write together: old value visible, then new value
        bus_address = 4'h8;
        bus_data_i  = 32'h55;
        bus_read    = 1'b1;
        bus_write   = 1'b1;
        #1;
        check("rw_pre_write", bus_data_o, 32'h105);
        @(posedge clk_bus);
        #1;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        check("rw_post_write", bus_data_o, 32'h55);

        // Prescaler field
        do_write(4'h0, 32'h0);
        do_write(4'h4, 32'h0);
        do_write(4'h0, 32'h0003_0001);
`ifdef BUS_TIMER_PRESCALER_EN
        read_check(4'h0, 32'h0003_0001, "ctrl_div_readback");
        read_check(4'h4, 32'd0, "presc_start");
        step(3);
        read_check(4'h4, 32'd0, "presc_hold");
        step(1);
        read_check(4'h4, 32'd1, "presc_tick1");
        step(4);
        read_check(4'h4, 32'd2, "presc_tick2");
`else
        read_check(4'h0, 32'h0000_0001, "ctrl_div_ignored");
        read_check(4'h4, 32'd0, "nopresc_start");
        step(3);
        read_check(4'h4, 32'd3, "nopresc_3");
        step(1);
        read_check(4'h4, 32'd4, "nopresc_4");
`endif

        // Asynchronous reset with irq high
        do_write(4'h0, 32'h0);
        do_write(4'h8, 32'd2);
        do_write(4'h4, 32'd0);
        do_write(4'h0, 32'h7);
        step(3);
        irq_check(1'b1, "irq_before_reset");
        read_check(4'h4, 32'd0, "count_before_reset");
        #1;
        rst_n = 1'b0;
        #1;
        irq_check(1'b0, "async_rst_irq");
        read_check(4'h0, 32'h0, "async_rst_ctrl");
        read_check(4'h4, 32'h0, "async_rst_count");
        read_check(4'h8, 32'hFFFF_FFFF, "async_rst_compare");
        read_check(4'hC, 32'h0, "async_rst_status");
        step(1);
        rst_n = 1'b1;
        step(2);
        read_check(4'h4, 32'h0, "post_reset_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
